imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_byte_packer.sv | 49 ++++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// stream framing constants.
package imem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StDone,
    StErr
  } ld_state_e;

  // Bytes per header word and per data word.
  localparam int unsigned HdrBytes = 4;

  // Width of the byte index within a word.
  localparam int unsigned IdxW = $clog2(HdrBytes);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts stream bytes into a big-endian 32-bit word and flags the byte that
// completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [31:0] next_word_o,
  output logic        word_done_o
);

  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     shift_q, shift_d;

  // Next-state of the shifter; the first byte of a word ends up in bits 31:24.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (byte_en_i) begin
      idx_d   = idx_q + 1'b1;  // wraps to 0 after the last byte of a word
      shift_d = {shift_q[23:0], byte_i};
    end
  end

  // Word outputs; next_word_o lets the FSM decide on the completing byte itself.
  always_comb begin
    word_o      = shift_q;
    next_word_o = {shift_q[23:0], byte_i};
    word_done_o = byte_en_i && !clr_i && (idx_q == IdxW'(HdrBytes - 1));
  end

  // Shifter and byte index registers; reset drops any partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program image into instruction memory
// while holding the CPU, then releases it once the whole image is written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  ld_state_e   state_q, state_d;
  logic [31:0] k_q, k_d;  // index of the word being written
  logic [31:0] n_q, n_d;  // word count from the header

  logic        accept;
  logic        pk_clr;
  logic [31:0] pk_word;
  logic [31:0] pk_next_word;
  logic        pk_word_done;

  byte_packer u_byte_packer (
    .clk_i       (clk),
    .rst_i       (reset),
    .clr_i       (pk_clr),
    .byte_en_i   (accept),
    .byte_i      (byte_data),
    .word_o      (pk_word),
    .next_word_o (pk_next_word),
    .word_done_o (pk_word_done)
  );

  // Next-state, word counter and header length.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    pk_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHdr;
          pk_clr  = 1'b1;
        end
      end
      StHdr: begin
        if (pk_word_done) begin
          n_d = pk_next_word;
          k_d = '0;
          if (pk_next_word == 32'd0) begin
            state_d = StDone;
          end else if (pk_next_word > 32'(DEPTH)) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (pk_word_done) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        k_d = k_q + 32'd1;
        // n_q never exceeds DEPTH here, so k_q + 1 cannot wrap in this compare.
        if (k_q + 32'd1 < n_q) begin
          state_d = StData;
        end else begin
          state_d = StDone;
        end
      end
      StDone, StErr: begin
        if (start) begin
          state_d = StHdr;
          k_d     = '0;
          pk_clr  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state; reset forces the idle values in the same cycle.
  always_comb begin
    byte_ready = !reset && ((state_q == StHdr) || (state_q == StData));
    accept     = byte_valid && byte_ready;
    imem_we    = !reset && (state_q == StWrite);
    imem_addr  = reset ? BASE_ADDR : BASE_ADDR + (k_q << 2);
    imem_wdata = imem_we ? pk_word : 32'd0;
    cpu_hold   = reset || (state_q != StDone);
    load_done  = !reset && (state_q == StDone);
    load_err   = !reset && (state_q == StErr);
  end

  // State, word counter and length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, gapped, zero-length, full-depth,
// overflow, reload and mid-load reset scenarios.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int total;
  int bad;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  imem_loader #(
    .DEPTH     (64),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write seen mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after an idle gap and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout byte_ready=%b required=1", byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (load_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({byte_ready, imem_we, cpu_hold, load_done, load_err} !== 5'b00100) begin
      bad++;
      $display("FAIL reset_flags got=%b required=00100",
               {byte_ready, imem_we, cpu_hold, load_done, load_err});
    end
    total++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus addr=%h wdata=%h required=0/0", imem_addr, imem_wdata);
    end
    tick();
    reset = 1'b0;
    byte_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({byte_ready, imem_we, cpu_hold, load_done, load_err} !== 5'b00100 ||
        imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL idle_after_reset flags=%b addr=%h wdata=%h required=00100/0/0",
               {byte_ready, imem_we, cpu_hold, load_done, load_err}, imem_addr, imem_wdata);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic test_nominal();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h2001_0005, 0);
    @(negedge clk);
    total++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h2001_0005) begin
      bad++;
      $display("FAIL nominal_write0 we=%b addr=%h data=%h required=1/0/20010005",
               imem_we, imem_addr, imem_wdata);
    end
    send_word(32'h0021_0820, 0);
    @(negedge clk);
    total++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h0021_0820) begin
      bad++;
      $display("FAIL nominal_write1 we=%b addr=%h data=%h required=1/4/00210820",
               imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    total++;
    if ({load_done, cpu_hold, byte_ready, imem_we, load_err} !== 5'b10000) begin
      bad++;
      $display("FAIL nominal_done flags=%b required=10000",
               {load_done, cpu_hold, byte_ready, imem_we, load_err});
    end
    total++;
    if (wa.size() != 2) begin
      bad++;
      $display("FAIL nominal_write_count got=%0d required=2", wa.size());
    end
  endtask

  task automatic test_reload();
    wa.delete();
    wd.delete();
    pulse_start();
    @(negedge clk);
    total++;
    if ({load_done, cpu_hold, byte_ready} !== 3'b011) begin
      bad++;
      $display("FAIL reload_hdr flags=%b required=011", {load_done, cpu_hold, byte_ready});
    end
    tick();
    send_word(32'h0000_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
    wait_done();
    total++;
    if (load_done !== 1'b1 || wa.size() != 1 ||
        (wa.size() == 1 && (wa[0] !== 32'h0 || wd[0] !== 32'hDEAD_BEEF))) begin
      bad++;
      $display("FAIL reload_write done=%b count=%0d required=1/1 addr0 deadbeef",
               load_done, wa.size());
    end
  endtask

  task automatic test_zero_len();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'h0000_0000, 0);
    @(negedge clk);
    total++;
    if ({load_done, cpu_hold, byte_ready, load_err} !== 4'b1000) begin
      bad++;
      $display("FAIL zero_len_done flags=%b required=1000",
               {load_done, cpu_hold, byte_ready, load_err});
    end
    repeat (3) tick();
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL zero_len_writes got=%0d required=0", wa.size());
    end
  endtask

  task automatic test_full_depth();
    logic ok;
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd64, 0);
    for (int i = 0; i < 64; i++) begin
      send_word(32'hA500_0000 | 32'(i), 0);
    end
    wait_done();
    ok = (wa.size() == 64) && (load_done === 1'b1);
    for (int i = 0; i < wa.size() && i < 64; i++) begin
      if (wa[i] !== 32'(4 * i) || wd[i] !== (32'hA500_0000 | 32'(i))) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL full_depth count=%0d done=%b required=64/1 with addr 4*i data a50000i",
               wa.size(), load_done);
    end
  endtask

  task automatic test_overflow();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'h0000_0041, 0);
    @(negedge clk);
    total++;
    if ({load_err, cpu_hold, byte_ready, load_done} !== 4'b1100) begin
      bad++;
      $display("FAIL overflow_err flags=%b required=1100",
               {load_err, cpu_hold, byte_ready, load_done});
    end
    byte_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (byte_ready !== 1'b0 || load_err !== 1'b1 || wa.size() != 0) begin
      bad++;
      $display("FAIL overflow_hold ready=%b err=%b writes=%0d required=0/1/0",
               byte_ready, load_err, wa.size());
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic test_gapped();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'h0000_0002, 5);
    send_word(32'h2001_0005, 5);
    send_word(32'h0021_0820, 5);
    wait_done();
    total++;
    if (load_done !== 1'b1 || load_err !== 1'b0 || wa.size() != 2 ||
        (wa.size() == 2 && (wa[0] !== 32'h0 || wd[0] !== 32'h2001_0005 ||
                            wa[1] !== 32'h4 || wd[1] !== 32'h0021_0820))) begin
      bad++;
      $display("FAIL gapped_writes done=%b err=%b count=%0d required=1/0/2 matching nominal",
               load_done, load_err, wa.size());
    end
  endtask

  task automatic test_reset_mid();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h00;
    @(negedge clk);
    total++;
    if ({byte_ready, imem_we, cpu_hold, load_done, load_err} !== 5'b00100 ||
        imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_during flags=%b addr=%h wdata=%h required=00100/0/0",
               {byte_ready, imem_we, cpu_hold, load_done, load_err}, imem_addr, imem_wdata);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({byte_ready, imem_we, cpu_hold, load_done, load_err} !== 5'b00100 ||
        imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_idle flags=%b addr=%h wdata=%h required=00100/0/0",
               {byte_ready, imem_we, cpu_hold, load_done, load_err}, imem_addr, imem_wdata);
    end
    repeat (3) tick();
    byte_valid = 1'b0;
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_no_write got=%0d required=0", wa.size());
    end
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h2001_0005, 0);
    send_word(32'h0021_0820, 0);
    wait_done();
    total++;
    if (load_done !== 1'b1 || wa.size() != 2 ||
        (wa.size() == 2 && (wa[0] !== 32'h0 || wd[0] !== 32'h2001_0005 ||
                            wa[1] !== 32'h4 || wd[1] !== 32'h0021_0820))) begin
      bad++;
      $display("FAIL mid_reset_reload done=%b count=%0d required=1/2 matching nominal",
               load_done, wa.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_nominal();
    test_reload();
    test_zero_len();
    test_full_depth();
    test_overflow();
    test_gapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
